// File: rtl/wormy_pkg.sv
// ============================================================================
//  Module : wormy_pkg
//  Brief  : Shared grid dimensions and LED-scan state encoding.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wormy_pkg;

    localparam int GridDim  = 4;
    localparam int NumCells = GridDim * GridDim;

    typedef enum logic [0:0] {
        SCAN_BLANK = 1'b0,
        SCAN_DRIVE = 1'b1
    } scan_state_e;

endpackage

`default_nettype wire

// File: rtl/arena_scan.sv
// ============================================================================
//  Module : arena_scan
//  Brief  : Row-multiplexed 4x4 LED scanner with per-frame snapshot and
//           PWM-style brightness inside each row dwell.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arena_scan
    import wormy_pkg::*;
#(
    parameter int DwellCycles = 75,
    parameter int BlankCycles = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumCells-1:0] arena_on,
    input  logic [1:0]          brightness,
    output logic [GridDim-1:0]  row_en,
    output logic [GridDim-1:0]  col_on,
    output logic                frame_start
);

    localparam logic [7:0] c_blank_last = 8'(BlankCycles - 1);
    localparam logic [7:0] c_dwell_last = 8'(DwellCycles - 1);

    scan_state_e         state_q;
    logic [1:0]          row_q;
    logic [7:0]          cnt_q;
    logic [NumCells-1:0] arena_q;
    logic [1:0]          bright_q;
    logic [GridDim-1:0]  row_en_q;
    logic [GridDim-1:0]  col_on_q;
    logic                frame_start_q;

    logic [9:0]          w_lit;
    logic [GridDim-1:0]  w_cols;

    // Lit cycles per dwell: quarter steps of the dwell, at most 4*255 so 10 bits suffice.
    assign w_lit  = ((10'(bright_q) + 10'd1) * 10'(DwellCycles)) >> 2;
    assign w_cols = arena_q[GridDim*row_q +: GridDim];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= SCAN_BLANK;
            row_q         <= 2'd0;
            cnt_q         <= 8'd0;
            arena_q       <= '0;
            bright_q      <= 2'd0;
            row_en_q      <= '0;
            col_on_q      <= '0;
            frame_start_q <= 1'b0;
        end else begin
            row_en_q      <= '0;
            col_on_q      <= '0;
            frame_start_q <= 1'b0;
            case (state_q)
                SCAN_BLANK: begin
                    if (row_q == 2'd0 && cnt_q == 8'd0) begin
                        arena_q       <= arena_on;
                        bright_q      <= brightness;
                        frame_start_q <= 1'b1;
                    end
                    if (cnt_q == c_blank_last) begin
                        state_q <= SCAN_DRIVE;
                        cnt_q   <= 8'd0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SCAN_DRIVE: begin
                    row_en_q <= GridDim'(1) << row_q;
                    col_on_q <= ({2'b00, cnt_q} < w_lit) ? w_cols : '0;
                    if (cnt_q == c_dwell_last) begin
                        state_q <= SCAN_BLANK;
                        cnt_q   <= 8'd0;
                        row_q   <= row_q + 2'd1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= SCAN_BLANK;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign row_en      = row_en_q;
    assign col_on      = col_on_q;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_arena_scan.sv
// ============================================================================
//  Module : tb_arena_scan
//  Brief  : Scoreboard bench for arena_scan (Dwell=8, Blank=2, period 40).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arena_scan;

    localparam int DWELL  = 8;
    localparam int BLANK  = 2;
    localparam int SLOT   = DWELL + BLANK;
    localparam int PERIOD = 4 * SLOT;

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        logic       fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] arena_on = 16'h0;
    logic [1:0]  brightness = 2'd0;
    logic [3:0]  row_en;
    logic [3:0]  col_on;
    logic        frame_start;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: time since reset release and the frame's captured inputs.
    int          m_t = 0;
    logic [15:0] m_snap = 16'h0;
    logic [1:0]  m_bright = 2'd0;

    arena_scan #(.DwellCycles(DWELL), .BlankCycles(BLANK)) dut (
        .clk        (clk),
        .rst        (rst),
        .arena_on   (arena_on),
        .brightness (brightness),
        .row_en     (row_en),
        .col_on     (col_on),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs and queue the outputs they produce after the next edge.
    task automatic step(input logic r, input logic [15:0] a, input logic [1:0] b);
        exp_t e;
        int   p, slot_row, pos, lit;
        @(negedge clk);
        rst = r; arena_on = a; brightness = b;
        e.row = 4'h0; e.col = 4'h0; e.fs = 1'b0;
        if (r) begin
            m_t = 0; m_snap = 16'h0; m_bright = 2'd0;
        end else begin
            p        = m_t % PERIOD;
            slot_row = p / SLOT;
            pos      = p % SLOT;
            if (p == 0) begin
                e.fs = 1'b1;
                m_snap = a;
                m_bright = b;
            end
            if (pos >= BLANK) begin
                lit   = ((int'(m_bright) + 1) * DWELL) / 4;
                e.row = 4'(1 << slot_row);
                if ((pos - BLANK) < lit) e.col = m_snap[4*slot_row +: 4];
            end
            m_t++;
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n, input logic [15:0] a, input logic [1:0] b);
        for (int i = 0; i < n; i++) step(1'b0, a, b);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set.
    int cyc = 0;
    int last_fs = -1;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (row_en !== e.row) begin
                    n_bad++;
                    $display("FAIL row_en cyc=%0d got=%b exp=%b", cyc, row_en, e.row);
                end
                n_cmp++;
                if (col_on !== e.col) begin
                    n_bad++;
                    $display("FAIL col_on cyc=%0d got=%b exp=%b", cyc, col_on, e.col);
                end
                n_cmp++;
                if (frame_start !== e.fs) begin
                    n_bad++;
                    $display("FAIL frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, e.fs);
                end
                n_cmp++;
                if (!(row_en == 4'h0 || $onehot(row_en))) begin
                    n_bad++;
                    $display("FAIL onehot cyc=%0d got=%b exp=zero_or_onehot", cyc, row_en);
                end
                n_cmp++;
                if (row_en == 4'h0 && col_on != 4'h0) begin
                    n_bad++;
                    $display("FAIL col_when_blank cyc=%0d got=%b exp=0000", cyc, col_on);
                end
                if (rst) begin
                    last_fs = -1;
                end else if (frame_start === 1'b1) begin
                    if (last_fs >= 0) begin
                        n_cmp++;
                        if (cyc - last_fs != PERIOD) begin
                            n_bad++;
                            $display("FAIL fs_spacing cyc=%0d got=%0d exp=%0d", cyc, cyc - last_fs, PERIOD);
                        end
                    end
                    last_fs = cyc;
                end
            end
        end
    end

    initial begin
        // Reset release, sparse map at full brightness, two frames.
        for (int i = 0; i < 3; i++) step(1'b1, 16'h0013, 2'd3);
        run(2 * PERIOD + 5, 16'h0013, 2'd3);
        // Minimum brightness, all cells lit.
        step(1'b1, 16'hFFFF, 2'd0);
        run(PERIOD + 5, 16'hFFFF, 2'd0);
        // Mid-frame map change only shows from the next capture.
        step(1'b1, 16'h0001, 2'd3);
        run(15, 16'h0001, 2'd3);
        run(2 * PERIOD, 16'h8000, 2'd3);
        // Reset pulse in the middle of row 2's dwell.
        step(1'b1, 16'h5A5A, 2'd2);
        run(25, 16'h5A5A, 2'd2);
        step(1'b1, 16'h5A5A, 2'd2);
        run(PERIOD + 5, 16'hA5C3, 2'd1);
        // Random run with occasional resets.
        for (int i = 0; i < 1000; i++)
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 16'($urandom), 2'($urandom_range(0, 3)));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            if (exp_q.size() == 0) break;
        end
        #2;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
